// File: rtl/data_mem_lsu.sv
// RV32I data memory for the MEM stage: byte/half/word loads and stores selected by
// funct3, registered load data one cycle after the request, fault flagging, and an
// optional zero sweep of the whole array after reset.

// One byte lane of the data array: a single read/write port with combinational read.
module data_mem_lane #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  // Lane write port
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module data_mem_lsu #(
  parameter int DEPTH_WORDS   = 256,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        wr_en_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  output logic        ready_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        misalign_o
);
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t  state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          sweep;

  logic [1:0]    b;
  logic [AW-1:0] word_idx;
  logic          acc, is_store, is_load, fault;

  logic [NUM_LANES-1:0]            st_be;
  logic [NUM_LANES-1:0][VEC_W-1:0] st_data;
  logic [NUM_LANES-1:0]            lane_we;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_wd;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_rd;
  logic [AW-1:0]                   mem_addr;

  logic [31:0] rd_word, rd_shift, ld_val;

  // Upper address bits alias onto the array and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[31:AW+2];

  // FSM state and sweep pointer register
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (INIT_ON_RESET) state <= S_INIT;
      else               state <= S_IDLE;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next state: INIT walks every word once, then parks in IDLE
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sweep     = 1'b0;
    case (state)
      S_INIT: begin
        sweep   = 1'b1;
        ptr_nxt = ptr + AW'(1);
        if (ptr == AW'(DEPTH_WORDS - 1)) state_nxt = S_IDLE;
      end
      default: ;
    endcase
  end

  // Gate on reset so nothing is accepted while reset is held
  assign ready_o  = reset && (state == S_IDLE);
  assign b        = address_i[1:0];
  assign word_idx = address_i[AW+1:2];
  assign acc      = req_i && ready_o;
  assign is_store = acc && wr_en_i;
  assign is_load  = acc && !wr_en_i;

  // Fault decode: illegal funct3 for the direction, or unaligned for the size
  always_comb begin
    fault = 1'b0;
    case (funct3_i)
      3'b000:  fault = 1'b0;
      3'b001:  fault = b[0];
      3'b010:  fault = |b;
      3'b100:  fault = wr_en_i;
      3'b101:  fault = wr_en_i | b[0];
      default: fault = 1'b1;
    endcase
  end

  // Store lane enables and lane-replicated store data
  always_comb begin
    st_be   = '0;
    st_data = '0;
    case (funct3_i[1:0])
      2'b00: begin
        st_be   = 4'b0001 << b;
        st_data = {4{write_data_i[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << b;
        st_data = {2{write_data_i[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = write_data_i;
      end
    endcase
  end

  // The sweep owns the port during INIT; requests are never accepted then.
  assign mem_addr = sweep ? ptr : word_idx;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_we[l] = sweep || (is_store && !fault && st_be[l]);
    assign lane_wd[l] = sweep ? '0 : st_data[l];

    data_mem_lane #(.DEPTH(DEPTH_WORDS), .AW(AW), .W(VEC_W)) u_lane (
      .clk   (clk),
      .we    (lane_we[l]),
      .addr  (mem_addr),
      .wdata (lane_wd[l]),
      .rdata (lane_rd[l])
    );
  end

  assign rd_word  = lane_rd;
  assign rd_shift = rd_word >> {b, 3'b000};

  // Load extraction and sign/zero extension
  always_comb begin
    ld_val = '0;
    case (funct3_i)
      3'b000:  ld_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  ld_val = rd_word;
      3'b100:  ld_val = {24'b0, rd_shift[7:0]};
      3'b101:  ld_val = {16'b0, rd_shift[15:0]};
      default: ld_val = '0;
    endcase
  end

  // Registered response: data holds between loads, pulses last one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      rd_valid_o <= is_load;
      misalign_o <= acc && fault;
      if (is_load) rd_data_o <= fault ? 32'h0 : ld_val;
    end
  end
endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: directed cases from the block's behaviour list plus a
// randomized run, all checked against a byte-array reference model.
module tb_data_mem_lsu;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i, wr_en_i;
  logic [2:0]  funct3_i;
  logic [31:0] address_i, write_data_i;
  logic        ready_o, rd_valid_o, misalign_o;
  logic [31:0] rd_data_o;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  mb [DEPTH*4];
  logic [31:0] exp_rd;

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .INIT_ON_RESET(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
    .wr_en_i      (wr_en_i),
    .funct3_i     (funct3_i),
    .address_i    (address_i),
    .write_data_i (write_data_i),
    .ready_o      (ready_o),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic int lin(input logic [31:0] a);
    return int'(((a >> 2) % DEPTH) * 4 + (a % 4));
  endfunction

  // Access size in bytes is 1<<funct3[1:0]; legality depends on direction.
  function automatic bit model_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int nb;
    bit legal;
    nb = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((a % nb) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int nb, base;
    logic [31:0] v, mask;
    nb = 1 << f3[1:0];
    base = lin(a);
    v = 0;
    for (int i = 0; i < nb; i++) v = v | (32'(mb[base + i]) << (8 * i));
    if (!f3[2] && nb < 4) begin
      mask = (32'd1 << (8 * nb)) - 1;
      if (v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH * 4; i++) mb[i] = 8'h00;
  endtask

  // One access in IDLE: drive, take one edge, compare the registered response.
  task automatic step(input logic rq, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    bit flt;
    int nb, base;
    chk("ready_idle", {31'b0, ready_o}, 32'd1);
    req_i = rq; wr_en_i = we; funct3_i = f3; address_i = a; write_data_i = wd;
    flt = model_fault(we, f3, a);
    if (rq && !we) exp_rd = flt ? 32'h0 : model_load(f3, a);
    if (rq && we && !flt) begin
      nb = 1 << f3[1:0];
      base = lin(a);
      for (int i = 0; i < nb; i++) mb[base + i] = wd[8*i +: 8];
    end
    @(posedge clk); #1;
    req_i = 1'b0;
    chk("rd_valid", {31'b0, rd_valid_o}, {31'b0, rq && !we});
    chk("misalign", {31'b0, misalign_o}, {31'b0, rq && flt});
    chk("rd_data", rd_data_o, exp_rd);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (ready_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [31:0] a;
    reset = 1'b0; req_i = 1'b0; wr_en_i = 1'b0; funct3_i = 3'd0;
    address_i = '0; write_data_i = '0; exp_rd = '0;
    model_clear();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready_o}, 32'd0);
    chk("rst_valid", {31'b0, rd_valid_o}, 32'd0);
    chk("rst_mis", {31'b0, misalign_o}, 32'd0);
    chk("rst_data", rd_data_o, 32'd0);

    // init sweep length, requests during INIT are ignored
    reset = 1'b1;
    req_i = 1'b1; wr_en_i = 1'b1; funct3_i = 3'd2; address_i = 32'h0; write_data_i = 32'hDEADBEEF;
    wait_init(n);
    req_i = 1'b0;
    chk("init_len", n, DEPTH);
    step(1, 0, 3'd2, 32'h0, 0);
    chk("init_zero0", rd_data_o, 32'h0);
    step(1, 0, 3'd2, 32'h3C, 0);
    chk("init_zero15", rd_data_o, 32'h0);

    // byte/half stores merge into a word
    step(1, 1, 3'd2, 32'h8, 32'h11223344);
    step(1, 1, 3'd0, 32'hA, 32'h000000AB);
    step(1, 1, 3'd1, 32'h8, 32'h0000BEEF);
    step(1, 0, 3'd2, 32'h8, 0);
    chk("merge", rd_data_o, 32'h11ABBEEF);

    // extension
    step(1, 1, 3'd2, 32'h4, 32'h80FF7F01);
    step(1, 0, 3'd0, 32'h6, 0); chk("lb", rd_data_o, 32'hFFFFFFFF);
    step(1, 0, 3'd4, 32'h6, 0); chk("lbu", rd_data_o, 32'h000000FF);
    step(1, 0, 3'd1, 32'h6, 0); chk("lh", rd_data_o, 32'hFFFF80FF);
    step(1, 0, 3'd5, 32'h4, 0); chk("lhu", rd_data_o, 32'h00007F01);

    // faults
    step(1, 1, 3'd2, 32'h2, 32'h55555555);
    chk("sw_fault_mis", {31'b0, misalign_o}, 32'd1);
    step(1, 0, 3'd2, 32'h0, 0); chk("sw_fault_nowrite", rd_data_o, 32'h0);
    step(1, 0, 3'd1, 32'h5, 0); chk("lh_fault", rd_data_o, 32'h0);
    step(1, 0, 3'd2, 32'h4, 0);
    step(1, 0, 3'd3, 32'h4, 0); chk("f3_011", rd_data_o, 32'h0);
    step(0, 0, 3'd2, 32'h4, 0);

    // back-to-back and aliasing
    step(1, 1, 3'd2, 32'h40, 32'hCAFEF00D);
    step(1, 0, 3'd2, 32'h40, 0); chk("b2b", rd_data_o, 32'hCAFEF00D);
    step(1, 0, 3'd2, 32'h40 + 4 * DEPTH, 0); chk("alias", rd_data_o, 32'hCAFEF00D);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
      step(($urandom_range(3, 0) != 0), $urandom_range(1, 0) == 1,
           3'($urandom_range(7, 0)), a, $urandom);
    end

    // reset during a pending load
    step(1, 1, 3'd2, 32'h8, 32'h12345678);
    req_i = 1'b1; wr_en_i = 1'b0; funct3_i = 3'd2; address_i = 32'h8;
    @(posedge clk); #1;
    req_i = 1'b0;
    chk("pend_valid", {31'b0, rd_valid_o}, 32'd1);
    chk("pend_data", rd_data_o, 32'h12345678);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_ready", {31'b0, ready_o}, 32'd0);
    chk("mid_data", rd_data_o, 32'h0);
    chk("mid_valid", {31'b0, rd_valid_o}, 32'd0);
    reset = 1'b1;
    wait_init(n);
    chk("reinit_len", n, DEPTH);

    // reset during INIT at ptr=7
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    chk("sweep_busy", {31'b0, ready_o}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("sweep_rst_ready", {31'b0, ready_o}, 32'd0);
    reset = 1'b1;
    wait_init(n);
    chk("sweep_restart_len", n, DEPTH);
    model_clear();
    exp_rd = 32'h0;
    step(1, 0, 3'd2, 32'h8, 0); chk("cleared8", rd_data_o, 32'h0);
    step(1, 0, 3'd2, 32'h4, 0); chk("cleared4", rd_data_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
